// File: rtl/fifo.sv
// Generic shared FIFO: power-of-two depth, one write port, one read port.
// Latency: a written word is visible on rd_dat/rd_vld from the following cycle.
// Backpressure: writes are dropped while full (caller must hold); reads while empty are ignored.
module fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_vld,
    input  logic [DATA_BITS-1:0] wr_dat,
    output logic                 full,
    input  logic                 rd_rdy,
    output logic [DATA_BITS-1:0] rd_dat,
    output logic                 rd_vld
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];
    // One extra pointer bit separates the full case from the empty case.
    logic [DEPTH_BITS:0]  wr_ptr;
    logic [DEPTH_BITS:0]  rd_ptr;
    logic                 do_wr;
    logic                 do_rd;

    assign rd_vld = (wr_ptr != rd_ptr);
    assign full   = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                    (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr[DEPTH_BITS-1:0]];

    // Pointer update; synchronous active-low reset empties the queue.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_dat;
    end
endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter merging NUM_REQ writers into one shared FIFO (optional packet lock: FIFO_ARBITER_PACKET_LOCK_EN).
// Latency: zero-cycle grant/ack; accepted word readable the following cycle.
// Backpressure: when the FIFO is full the winner stays on grant_o, ack_o is held low and the pointer freezes.
module fifo_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [NUM_REQ-1:0]             grant_o,
    input  logic                           read_i,
    output logic [DATA_BITS-1:0]           read_data_o,
    output logic                           read_ready_o
);
    localparam int RR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RR_BITS-1:0]   rr_q;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [RR_BITS-1:0]   win_idx;
    logic [RR_BITS-1:0]   cand;
    logic                 found;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_vld;
    logic [DATA_BITS-1:0] win_data;

`ifdef FIFO_ARBITER_PACKET_LOCK_EN
    logic                 lock_q;
    logic [RR_BITS-1:0]   owner_q;

    // While a packet is open only its owner may compete.
    always_comb begin
        eligible = req_i;
        if (lock_q) eligible = req_i & (NUM_REQ'(1) << owner_q);
    end

    // Open a lock on a non-last accepted word, close it on the owner's last word.
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (accept) begin
            lock_q  <= ~req_last_i[win_idx];
            owner_q <= win_idx;
        end
    end
`else
    logic unused_last;

    assign eligible    = req_i;
    assign unused_last = ^req_last_i;
`endif

    // Round-robin search starting at rr_q and wrapping modulo NUM_REQ.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = RR_BITS'((int'(rr_q) + i) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                win_idx     = cand;
            end
        end
    end

    assign grant_o      = grant;
    // Gating with reset keeps ack and ready low during the reset cycle itself.
    assign accept       = found && !fifo_full && !reset;
    assign ack_o        = accept ? grant : '0;
    assign win_data     = req_data_i[win_idx*DATA_BITS +: DATA_BITS];
    assign read_ready_o = fifo_vld && !reset;

    // Pointer moves just past the writer that got a word in; holds otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= '0;
        end else if (accept) begin
            rr_q <= (win_idx == RR_BITS'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    fifo #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset_n (~reset),
        .wr_vld  (accept),
        .wr_dat  (win_data),
        .full    (fifo_full),
        .rd_rdy  (read_i && read_ready_o),
        .rd_dat  (read_data_o),
        .rd_vld  (fifo_vld)
    );
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter (NUM_REQ=4, DATA_BITS=8, DEPTH_BITS=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
// Packet-lock scenarios run only when FIFO_ARBITER_PACKET_LOCK_EN is defined.
module tb_fifo_arbiter;
    logic        clock;
    logic        reset;
    logic [3:0]  req_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  ack_o;
    logic [3:0]  grant_o;
    logic        read_i;
    logic [7:0]  read_data_o;
    logic        read_ready_o;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_arbiter #(
        .NUM_REQ    (4),
        .DATA_BITS  (8),
        .DEPTH_BITS (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_i        (req_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .ack_o        (ack_o),
        .grant_o      (grant_o),
        .read_i       (read_i),
        .read_data_o  (read_data_o),
        .read_ready_o (read_ready_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let freshly driven inputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    initial begin
        reset      = 1'b1;
        req_i      = 4'hF;
        req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_last_i = 4'hF;
        read_i     = 1'b0;

        // Reset held for two edges: no acks, nothing readable.
        tick(); settle();
        check("rst_ack", 32'(ack_o), 32'h0);
        check("rst_ready", 32'(read_ready_o), 32'h0);
        tick();
        reset = 1'b0;
        settle();
        check("rst_rr_grant", 32'(grant_o), 32'h1);

        // Round robin with all writers requesting and reader always popping.
        read_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_ack%0d", k), 32'(ack_o), 32'(4'b0001 << (k % 4)));
            if (k > 0) check($sformatf("rr_data%0d", k), 32'(read_data_o), 32'(8'hA0 + ((k - 1) % 4)));
            tick(); settle();
        end

        // Fresh start for the full-FIFO scenario.
        reset = 1'b1; read_i = 1'b0; req_i = 4'h0;
        tick();
        reset = 1'b0;
        settle();
        check("idle_grant", 32'(grant_o), 32'h0);
        check("idle_ready", 32'(read_ready_o), 32'h0);
        tick();

        req_i = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            req_data_i = {24'h0, 8'(8'h11 + c)};
            settle();
            check($sformatf("fill_ack%0d", c), 32'(ack_o), 32'h1);
            tick();
        end
        req_data_i = {24'h0, 8'h15};
        settle();
        check("full_ack", 32'(ack_o), 32'h0);
        check("full_grant", 32'(grant_o), 32'h1);
        check("full_head", 32'(read_data_o), 32'h11);
        tick();
        read_i = 1'b1;
        settle();
        check("pop_full_ack", 32'(ack_o), 32'h0);
        check("pop_head", 32'(read_data_o), 32'h11);
        tick();
        read_i = 1'b0;
        settle();
        check("after_pop_ack", 32'(ack_o), 32'h1);
        check("after_pop_head", 32'(read_data_o), 32'h12);
        tick();
        req_i = 4'h0; read_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("drain%0d", c), 32'(read_data_o), 32'(8'h12 + c));
            tick();
        end
        settle();
        check("drained_ready", 32'(read_ready_o), 32'h0);

        // Wrap: move pointer to 3 via writer 2, then writers 3 and 0 compete.
        tick();
        req_i = 4'b0100;
        req_data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        settle();
        check("wrap_setup_ack", 32'(ack_o), 32'h4);
        tick();
        req_i = 4'b1001;
        settle();
        check("wrap_ack3", 32'(ack_o), 32'h8);
        check("wrap_data2", 32'(read_data_o), 32'hD2);
        tick(); settle();
        check("wrap_ack0", 32'(ack_o), 32'h1);
        check("wrap_data3", 32'(read_data_o), 32'hD3);
        tick();
        req_i = 4'h0;
        settle();
        check("wrap_data0", 32'(read_data_o), 32'hD0);

`ifdef FIFO_ARBITER_PACKET_LOCK_EN
        // Packet lock: writer 1 sends three words while writer 2 waits.
        reset = 1'b1; read_i = 1'b0;
        tick();
        reset = 1'b0;
        req_i = 4'b0110;
        for (int w = 0; w < 3; w++) begin
            req_data_i = {8'h00, 8'hC1, 8'(8'hB1 + w), 8'h00};
            req_last_i = (w == 2) ? 4'b0110 : 4'b0100;
            settle();
            check($sformatf("lock_ack%0d", w), 32'(ack_o), 32'h2);
            tick();
        end
        settle();
        check("lock_release_ack", 32'(ack_o), 32'h4);
        tick();
        req_i = 4'h0; read_i = 1'b1;
        for (int w = 0; w < 4; w++) begin
            settle();
            check($sformatf("lock_out%0d", w), 32'(read_data_o), (w < 3) ? 32'(8'hB1 + w) : 32'hC1);
            tick();
        end

        // Reset in the middle of a packet from writer 2.
        read_i = 1'b0;
        req_i = 4'b0100; req_last_i = 4'b0000;
        settle();
        check("midpkt_ack", 32'(ack_o), 32'h4);
        tick();
        reset = 1'b1; req_i = 4'b0101;
        settle();
        check("midpkt_rst_ack", 32'(ack_o), 32'h0);
        tick();
        reset = 1'b0;
        settle();
        check("midpkt_ready", 32'(read_ready_o), 32'h0);
        check("midpkt_winner", 32'(ack_o), 32'h1);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of writers (2..8).
REQ-002 SHALL have parameter DATA_BITS, default 8: word width.
REQ-003 SHALL have parameter DEPTH_BITS, default 2: log2 of shared FIFO depth.
REQ-004 SHALL have port clock  input  1: single clock; all state on posedge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port req_i  input  NUM_REQ: per-writer word-valid.
REQ-007 SHALL have port req_data_i  input  NUM_REQ*DATA_BITS: writer k data in bits [k*DATA_BITS +: DATA_BITS].
REQ-008 SHALL have port req_last_i  input  NUM_REQ: per-writer end-of-packet flag.
REQ-009 SHALL have port ack_o  output  NUM_REQ: word from writer k accepted this cycle.
REQ-010 SHALL have port grant_o  output  NUM_REQ: one-hot (or zero) current winner.
REQ-011 SHALL have port read_i  input  1: consumer pops head word.
REQ-012 SHALL have port read_data_o  output  DATA_BITS: head word.
REQ-013 SHALL have port read_ready_o  output  1: FIFO non-empty.

Function
REQ-014 SHALL register a round-robin pointer rr_q (width clog2(NUM_REQ)); grant_o = first set req_i bit searching rr_q, rr_q+1, ... wrapping modulo NUM_REQ; zero if req_i==0.
REQ-015 SHALL compute grant_o combinationally from req_i and registered state (zero-cycle arbitration).
REQ-016 SHALL drive ack_o = grant_o when FIFO not full, else all-zero; at most one ack bit set per cycle.
REQ-017 SHALL write req_data_i slice of the granted writer into the FIFO exactly when its ack bit is set.
REQ-018 SHALL, on an accepted word from writer k, set rr_q to (k+1) mod NUM_REQ on the next edge; otherwise rr_q holds.
REQ-019 SHALL, when FIFO full, keep grant_o showing the winner, deassert all ack_o, leave rr_q unchanged.
REQ-020 SHALL make an accepted word visible at read_data_o/read_ready_o no earlier than the following cycle.
REQ-021 SHALL pop on read_i & read_ready_o; read_i while empty is ignored; same-cycle pop and push both take effect.
REQ-022 SHALL ensure a writer requesting continuously is acked within NUM_REQ accepted words (no starvation), absent packet lock.

Reset
REQ-023 SHALL, with reset high at a clock edge, set rr_q=0, clear lock state, empty the FIFO.
REQ-024 SHALL, during reset cycle, drive ack_o=0 and read_ready_o=0; grant_o may be non-zero.
REQ-025 SHALL discard any partially written packet on mid-operation reset; no recovery of in-flight data.

Configuration
REQ-026 SHALL support macro FIFO_ARBITER_PACKET_LOCK_EN.
REQ-027 With macro defined: accepted word with req_last_i=0 from writer k SHALL set lock_q=1, owner_q=k; while locked grant_o SHALL be owner only (zero if owner not requesting); accepted word from owner with req_last_i=1 SHALL clear lock_q and advance rr_q per REQ-018.
REQ-028 Without macro: req_last_i SHALL be ignored, no lock/owner registers exist, arbitration per word.

Structure
REQ-029 SHALL instantiate exactly one sub-module, the existing fifo, with DATA_BITS/DEPTH_BITS passed through and reset inverted (fifo reset is active-low).
REQ-030 SHALL place no package; round-robin search and lock logic live in fifo_arbiter.

Verification
REQ-031 Reset: NUM_REQ=4, reset 2 cycles -> ack_o=0, read_ready_o=0, rr_q=0.
REQ-032 Round-robin: req_i=4'b1111 continuously, reader always popping -> acks in order 0,1,2,3,0,...
REQ-033 Full: reader idle, req_i=4'b0001, data 0x11..0x14 then 0x15 -> first 4 acked, 0x15 held unacked; one read_i -> 0x11 out, 0x15 acked next cycle.
REQ-034 Wrap: rr_q=3, req_i=4'b1001 -> writer 3 acked, then writer 0 next.
REQ-035 Lock (macro on): writer 1 sends 3-word packet last on word 3 while writer 2 requests -> FIFO holds w1,w1,w1 then w2.
REQ-036 Mid-packet reset (macro on): assert reset after word 1 of packet -> lock cleared, FIFO empty, writer 0 wins next.
